// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART serial transmitter with a one-byte holding register.
//               Each byte goes out LSB-first as: start bit, NB_DATA data bits,
//               an optional even-parity bit, then NB_STOP stop bits.
//               Bit timing comes from the shared 16x oversampling tick.
//               Optional feature macro: UART_TX_PARITY_EN (adds even parity).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1,
    parameter int SB_TICK = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_din,
    output logic               o_tx,
    output logic               o_tx_ready,
    output logic               o_tx_busy,
    output logic               o_tx_done_tick
);

    localparam int c_TICK_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int c_STOP_W = (NB_STOP > 1) ? $clog2(NB_STOP) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SB_TICK - 1);
    localparam logic [2:0]          c_BIT_LAST  = 3'(NB_DATA - 1);
    localparam logic [c_STOP_W-1:0] c_STOP_LAST = c_STOP_W'(NB_STOP - 1);

    // Line states; encodings outside this set fall back to IDLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [c_TICK_W-1:0] r_tick_cnt;
    logic [2:0]          r_bit_cnt;
    logic [c_STOP_W-1:0] r_stop_cnt;
    logic [NB_DATA-1:0]  r_shreg;
    logic                r_tx;
    logic                r_done;
    logic [NB_DATA-1:0]  r_hold_data;
    logic                r_hold_valid;
`ifdef UART_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is taken from a
    // copy of the byte captured when it is loaded.
    logic [NB_DATA-1:0]  r_par_byte;
`endif

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t              w_state_next;
    logic [c_TICK_W-1:0] w_tick_next;
    logic [2:0]          w_bit_next;
    logic [c_STOP_W-1:0] w_stop_next;
    logic [NB_DATA-1:0]  w_shreg_next;
    logic                w_tx_next;
    logic                w_done_next;
    logic                w_load;
    logic                w_accept;
`ifdef UART_TX_PARITY_EN
    logic [NB_DATA-1:0]  w_par_next;
`endif

    // A write is only taken while the holding register is empty.
    assign w_accept = i_tx_start & ~r_hold_valid;

    // Holding register: a transfer to the shifter takes priority over a write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= i_din;
        end
    end

    // Frame sequencer: next state, counters, shifter and line level.
    always_comb begin
        w_state_next = r_state;
        w_tick_next  = r_tick_cnt;
        w_bit_next   = r_bit_cnt;
        w_stop_next  = r_stop_cnt;
        w_shreg_next = r_shreg;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_tx_next    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (r_hold_valid) begin
                    w_load       = 1'b1;
                    w_tick_next  = '0;
                    w_state_next = S_START;
                end
            end

            S_START: begin
                if (i_s_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next  = '0;
                        w_bit_next   = '0;
                        w_state_next = S_DATA;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            S_DATA: begin
                if (i_s_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next  = '0;
                        w_shreg_next = r_shreg >> 1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_stop_next  = '0;
`ifdef UART_TX_PARITY_EN
                            w_state_next = S_PARITY;
`else
                            w_state_next = S_STOP;
`endif
                        end else begin
                            w_bit_next = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (i_s_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next  = '0;
                        w_state_next = S_STOP;
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end
`endif

            S_STOP: begin
                if (i_s_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_next = '0;
                        if (r_stop_cnt == c_STOP_LAST) begin
                            w_done_next = 1'b1;
                            // A waiting byte starts immediately, so frames
                            // run back-to-back with no idle gap.
                            if (r_hold_valid) begin
                                w_load       = 1'b1;
                                w_state_next = S_START;
                            end else begin
                                w_state_next = S_IDLE;
                            end
                        end else begin
                            w_stop_next = r_stop_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_tick_next  = '0;
                w_bit_next   = '0;
                w_stop_next  = '0;
            end
        endcase

        if (w_load) begin
            w_shreg_next = r_hold_data;
        end

`ifdef UART_TX_PARITY_EN
        w_par_next = w_load ? r_hold_data : r_par_byte;
`endif

        // The line level follows the state being entered so that o_tx and
        // the state register change on the same edge.
        case (w_state_next)
            S_IDLE:   w_tx_next = 1'b1;
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shreg_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = ^w_par_next;
`endif
            S_STOP:   w_tx_next = 1'b1;
            default:  w_tx_next = 1'b1;
        endcase
    end

    // State, counters, shifter and registered line output.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= '0;
            r_shreg    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_tick_cnt <= w_tick_next;
            r_bit_cnt  <= w_bit_next;
            r_stop_cnt <= w_stop_next;
            r_shreg    <= w_shreg_next;
            r_tx       <= w_tx_next;
            r_done     <= w_done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Byte copy used only for the parity bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_par_byte <= '0;
        end else begin
            r_par_byte <= w_par_next;
        end
    end
`endif

    assign o_tx           = r_tx;
    assign o_tx_ready     = ~r_hold_valid;
    assign o_tx_busy      = (r_state != S_IDLE);
    assign o_tx_done_tick = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed, table-driven bench for uart_tx (8N1 instance plus
//               an 8N2 instance for the two-stop-bit case).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int c_SB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int c_P = 1;
`else
    localparam int c_P = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tick_en = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [7:0] din1 = '0, din2 = '0;
    logic       tx1, ready1, busy1, done1;
    logic       tx2, ready2, busy2, done2;

    int n_vec = 0;
    int n_bad = 0;

    uart_tx #(.NB_DATA(8), .NB_STOP(1), .SB_TICK(c_SB)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_s_tick(s_tick),
        .i_tx_start(start1), .i_din(din1),
        .o_tx(tx1), .o_tx_ready(ready1), .o_tx_busy(busy1), .o_tx_done_tick(done1)
    );

    uart_tx #(.NB_DATA(8), .NB_STOP(2), .SB_TICK(c_SB)) u_dut2 (
        .i_clk(clk), .i_reset(reset), .i_s_tick(s_tick),
        .i_tx_start(start2), .i_din(din2),
        .o_tx(tx2), .o_tx_ready(ready2), .o_tx_busy(busy2), .o_tx_done_tick(done2)
    );

    always #5 clk = ~clk;

    // Baud tick: one clock high every 4 clocks while enabled.
    initial begin : g_tick
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                tcnt++;
                s_tick = (tcnt % 4 == 0);
            end else begin
                tcnt = 0;
                s_tick = 1'b0;
            end
        end
    end

    initial begin : g_watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0] din;
        logic       par;   // hand-computed even parity of din
    } vec_t;

    function automatic logic get_tx(input int d);
        return (d == 2) ? tx2 : tx1;
    endfunction

    function automatic logic get_done(input int d);
        return (d == 2) ? done2 : done1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_write(input int d, input logic [7:0] v);
        @(negedge clk);
        if (d == 2) begin start2 = 1'b1; din2 = v; end
        else        begin start1 = 1'b1; din1 = v; end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Follow one frame by counting consumed ticks from the start-bit edge;
    // sample each bit mid-period and check the done pulse position.
    task automatic check_frame(input int d, input logic [7:0] v, input logic par,
                               input int nstop, input string tag);
        logic [15:0] eb;
        int nb, ticks, clks, early;
        logic tk;
        nb = 1 + 8 + c_P + nstop;
        eb = '1;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[i+1] = v[i];
        if (c_P == 1) eb[9] = par;
        clks = 0;
        while (get_tx(d) !== 1'b0 && clks < 100) begin
            @(posedge clk); #1;
            clks++;
        end
        chk({tag, "_startbit"}, int'(get_tx(d)), 0);
        ticks = 0; clks = 0; early = 0;
        while (ticks < c_SB*nb && clks < c_SB*nb*4 + 64) begin
            @(posedge clk);
            tk = s_tick;
            clks++;
            if (tk) ticks++;
            #1;
            if (tk && (ticks % c_SB) == c_SB/2)
                chk($sformatf("%s_bit%0d", tag, ticks/c_SB), int'(get_tx(d)), int'(eb[ticks/c_SB]));
            if (ticks < c_SB*nb && get_done(d) === 1'b1) early++;
        end
        chk({tag, "_ticks"}, ticks, c_SB*nb);
        chk({tag, "_done"}, int'(get_done(d)), 1);
        chk({tag, "_early_done"}, early, 0);
    endtask

    initial begin : g_main
        vec_t vecs[6];
        int n, lows, dones, ticks, clks;
        logic lvl, tk;

        vecs[0] = '{din: 8'h07, par: 1'b1};
        vecs[1] = '{din: 8'h03, par: 1'b0};
        vecs[2] = '{din: 8'h80, par: 1'b1};
        vecs[3] = '{din: 8'h00, par: 1'b0};
        vecs[4] = '{din: 8'hFF, par: 1'b0};
        vecs[5] = '{din: 8'hA5, par: 1'b0};

        // ---------------- reset ----------------
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", int'(tx1), 1);
        chk("rst_ready", int'(ready1), 1);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_tx2", int'(tx2), 1);
        @(negedge clk);
        reset = 1'b0;
        tick_en = 1'b1;
        repeat (3) @(negedge clk);

        // ---------------- latency and bit lengths, 0x55 ----------------
        start1 = 1'b1; din1 = 8'h55;
        @(posedge clk); #1;
        chk("lat_ready_low", int'(ready1), 0);
        chk("lat_tx_still_high", int'(tx1), 1);
        chk("lat_busy_still_low", int'(busy1), 0);
        @(negedge clk);
        start1 = 1'b0;
        @(posedge clk); #1;
        chk("lat_tx_low", int'(tx1), 0);
        chk("lat_busy", int'(busy1), 1);
        chk("lat_ready_back", int'(ready1), 1);
        lvl = 1'b0;
        for (int r = 0; r < 9; r++) begin
            n = 0;
            while (tx1 === lvl && n < 300) begin
                @(posedge clk); #1;
                n++;
            end
            if (r == 0) chk("run_start_in_range", int'(n >= 61 && n <= 64), 1);
            else if (r == 8) chk("run_d7", n, (c_P == 1) ? 128 : 64);
            else chk($sformatf("run_d%0d", r-1), n, 64);
            lvl = ~lvl;
        end
        n = 0;
        while (done1 !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("stop_len_to_done", n, 64);
        @(posedge clk); #1;
        chk("done_one_clock", int'(done1), 0);
        chk("idle_after_55", int'(busy1), 0);

        // ---------------- table of single frames ----------------
        for (int i = 0; i < 6; i++) begin
            do_write(1, vecs[i].din);
            check_frame(1, vecs[i].din, vecs[i].par, 1, $sformatf("v%0d", i));
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle", i), int'(busy1), 0);
        end

        // ---------------- back-to-back, third write refused ----------------
        tick_en = 1'b0;
        do_write(1, 8'hA3);
        @(posedge clk); #1;
        chk("b2b_first_loaded", int'(ready1), 1);
        do_write(1, 8'h0F);
        chk("b2b_full", int'(ready1), 0);
        do_write(1, 8'h5A);
        chk("b2b_still_full", int'(ready1), 0);
        tick_en = 1'b1;
        check_frame(1, 8'hA3, 1'b0, 1, "b2b_a3");
        chk("b2b_contig_tx", int'(tx1), 0);
        chk("b2b_contig_busy", int'(busy1), 1);
        check_frame(1, 8'h0F, 1'b0, 1, "b2b_0f");
        lows = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (tx1 !== 1'b1) lows++;
        end
        chk("b2b_no_third", lows, 0);
        chk("b2b_ready_end", int'(ready1), 1);

        // ---------------- two stop bits ----------------
        do_write(2, 8'hFF);
        check_frame(2, 8'hFF, 1'b0, 2, "stop2");
        @(posedge clk); #1;
        chk("stop2_idle", int'(busy2), 0);

        // ---------------- reset mid-frame ----------------
        tick_en = 1'b0;
        do_write(1, 8'h00);
        @(posedge clk); #1;
        do_write(1, 8'hC3);
        chk("mid_buffered", int'(ready1), 0);
        tick_en = 1'b1;
        ticks = 0; clks = 0;
        while (ticks < c_SB*4 + c_SB/2 && clks < 400) begin
            @(posedge clk);
            tk = s_tick;
            clks++;
            if (tk) ticks++;
            #1;
        end
        chk("mid_bit3_low", int'(tx1), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_tx", int'(tx1), 1);
        chk("mid_rst_ready", int'(ready1), 1);
        chk("mid_rst_busy", int'(busy1), 0);
        chk("mid_rst_done", int'(done1), 0);
        @(negedge clk);
        reset = 1'b0;
        lows = 0; dones = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (tx1 !== 1'b1) lows++;
            if (done1 === 1'b1) dones++;
        end
        chk("mid_no_frame", lows, 0);
        chk("mid_no_done", dones, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
